start_ctrl: RTL and testbench
=============================

# start_ctrl

Game-start controller: the credit-consuming end of the coin/credit path. It debounces the 1P/2P start switches, checks the credit status flags from the coin accumulator, and issues the debit strobes (`_1_CR_START_N`, `_2_CR_START`) that make the accumulator count down. It then tracks the attract/play/game-over state for the rest of the game logic. It sits between the cabinet start switches, the coin accumulator and the playfield/serve logic.

## Interface
Parameters:
- DEBOUNCE, 16: consecutive CLK_DRV cycles a synchronized switch level must persist before the filtered level changes (≥1)
- PULSE_W, 4: width in CLK_DRV cycles of the `_1_CR_START_N` low pulse (≥1)
- OVER_HOLD, 1024: CLK_DRV cycles spent in OVER before returning to attract (≥1)

Ports:
- CLK_DRV in 1: system clock; all state changes on its rising edge
- RESET_N in 1: asynchronous, active-low reset
- START1 in 1: raw 1-player start switch, active high, asynchronous
- START2 in 1: raw 2-player start switch, active high, asynchronous
- _1_OR_2_CREDIT in 1: high when credits ≥1 (from coin accumulator)
- _2_CREDIT in 1: high when credits ≥2
- _8V in 1: video counter bit; synchronous to CLK_DRV
- GAME_OVER in 1: one-cycle pulse from ball/serve logic when the last ball is lost
- _1_CR_START_N out 1: active-low single-credit debit strobe
- _2_CR_START out 1: active-high two-credit debit window; the accumulator gates it with `_8V`
- ATTRACT out 1: high in IDLE and OVER
- ATTRACT_N out 1: always the inverse of ATTRACT
- PLAYING out 1: high in PLAY only
- PLAYERS2 out 1: high if the current or last game was started with START2

## Operation
- **Switch path, per switch:**
  - 2-FF synchronizer, then debounce counter.
  - The counter clears whenever the synchronized level equals the filtered level; otherwise it increments.
  - When it reaches DEBOUNCE, the filtered level takes the synchronized level and the counter clears.
  - A start event is a filtered 0→1 transition, valid for exactly one cycle.
- **States:** IDLE, DEB1, DEB2, PLAY, OVER.
- **IDLE:**
  - start2 event and `_2_CREDIT`=1 → DEB2, PLAYERS2←1.
  - Otherwise, start1 event and `_1_OR_2_CREDIT`=1 → DEB1, PLAYERS2←0.
  - Simultaneous events: START2 wins if `_2_CREDIT`=1; else START1 is evaluated.
  - Events without sufficient credit are discarded, not queued.
- **DEB1:** `_1_CR_START_N`=0 for exactly PULSE_W cycles, then → PLAY.
- **DEB2:**
  - `_2_CR_START`=1 from state entry.
  - Falling edges of `_8V` are counted via a registered previous value.
  - On the cycle the second falling edge is detected → PLAY, and `_2_CR_START` drops on that edge.
- **PLAY:** GAME_OVER=1 → OVER.
- **OVER:** hold counter runs OVER_HOLD cycles, then → IDLE.
- **Ignored events:**
  - Start events outside IDLE are dropped, including while a debit is in progress.
  - GAME_OVER outside PLAY is ignored.
- **Outputs:** all registered, decoded from next state.
  - ATTRACT = (IDLE or OVER).
  - PLAYING = PLAY.
  - PLAYERS2 holds its value until the next accepted start.
- **Credit flags:** sampled only at the IDLE decision cycle; changes during DEB1/DEB2 do not alter the sequence.

## Timing
- **Reset values:**
  - IDLE; `_1_CR_START_N`=1, `_2_CR_START`=0.
  - ATTRACT=1, ATTRACT_N=0, PLAYING=0, PLAYERS2=0.
  - Synchronizers, filtered levels and all counters = 0.
- **Reset mid-operation:** immediate return to reset values. A debit pulse or window in progress is truncated. The credit counter is not re-debited.
- **Switch held through reset:** produces one start event DEBOUNCE+2 cycles after RESET_N deasserts.
- **Latency:** raw switch rise at cycle 0 (stable) → filtered edge at cycle 2+DEBOUNCE → debit output asserted at cycle 3+DEBOUNCE.
- **DEB1 duration:** `_1_CR_START_N` low for cycles [3+DEBOUNCE, 3+DEBOUNCE+PULSE_W−1]; PLAYING=1 at 3+DEBOUNCE+PULSE_W.
- **DEB2 duration:** depends on `_8V` phase. Entry while `_8V`=1 counts the upcoming fall as the first edge. PLAYING rises in the same cycle `_2_CR_START` falls.
- **GAME_OVER:** pulse at cycle n → ATTRACT=1 at n+1 → PLAYING=0 at n+1 → IDLE at n+1+OVER_HOLD. Starts are accepted from IDLE onwards.
- **Release:** no output change on switch release; a new press requires a filtered 0 then a filtered 1.

## Test plan
- **1P start:** DEBOUNCE=4, PULSE_W=4, `_1_OR_2_CREDIT`=1; START1 rises at cycle 0 → `_1_CR_START_N` low for cycles 7–10, PLAYING=1 and ATTRACT=0 at cycle 11, PLAYERS2=0.
- **2P start:** `_2_CREDIT`=1, `_8V` period 16 cycles; START2 pressed → `_2_CR_START` high across exactly two `_8V` falling edges, then PLAYING=1, PLAYERS2=1.
- **No credit:** `_1_OR_2_CREDIT`=0, `_2_CREDIT`=0; press both switches → no debit strobe, state stays IDLE. Raising credit later without a new press → still IDLE.
- **Bounce and priority:** START1 toggling every 2 cycles with DEBOUNCE=4 → no event. Both switches pressed in the same cycle with `_2_CREDIT`=1 → only `_2_CR_START` fires.
- **Game end:** OVER_HOLD=8; GAME_OVER pulse in PLAY → ATTRACT=1 next cycle, IDLE 8 cycles later. A START1 press during OVER is ignored; a press in IDLE is accepted.
- **Reset mid-debit:** RESET_N low during cycle 2 of the DEB1 pulse → `_1_CR_START_N`=1 and ATTRACT=1 immediately (asynchronously). After release, a held START1 re-triggers once after DEBOUNCE+2 cycles.

Source files
------------

// File: rtl/start_ctrl.sv
// rtl/start_ctrl.sv - game-start controller: start switch debounce, credit debit strobes, attract/play state
module start_ctrl #(
  parameter int DEBOUNCE  = 16,
  parameter int PULSE_W   = 4,
  parameter int OVER_HOLD = 1024
) (
  input  logic CLK_DRV,
  input  logic RESET_N,
  input  logic START1,
  input  logic START2,
  input  logic _1_OR_2_CREDIT,
  input  logic _2_CREDIT,
  input  logic _8V,
  input  logic GAME_OVER,
  output logic _1_CR_START_N,
  output logic _2_CR_START,
  output logic ATTRACT,
  output logic ATTRACT_N,
  output logic PLAYING,
  output logic PLAYERS2
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int PW = $clog2(PULSE_W + 1);
  localparam int HW = $clog2(OVER_HOLD + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_W - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(OVER_HOLD - 1);

  typedef enum logic [2:0] {IDLE, DEB1, DEB2, PLAY, OVER} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    sw_raw;
  logic [1:0]    sw_s1;
  logic [1:0]    sw_s2;
  logic [1:0]    sw_filt;
  logic [1:0]    sw_filt_d;
  logic [DW-1:0] deb_cnt [2];
  logic          start1_ev;
  logic          start2_ev;
  logic          v8_d;
  logic          v8_fall;
  logic          fall_seen;
  logic [PW-1:0] pulse_cnt;
  logic [HW-1:0] hold_cnt;

  assign sw_raw = {START2, START1};

  // Bit 0 is START1, bit 1 is START2; the filtered level only moves after DEBOUNCE stable cycles.
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      sw_filt   <= '0;
      sw_filt_d <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sw_s1     <= sw_raw;
      sw_s2     <= sw_s1;
      sw_filt_d <= sw_filt;
      for (int i = 0; i < 2; i++) begin
        if (sw_s2[i] == sw_filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          sw_filt[i] <= sw_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign start1_ev = sw_filt[0] & ~sw_filt_d[0];
  assign start2_ev = sw_filt[1] & ~sw_filt_d[1];
  assign v8_fall   = v8_d & ~_8V;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start2_ev && _2_CREDIT)
          state_nxt = DEB2;
        else if (start1_ev && _1_OR_2_CREDIT)
          state_nxt = DEB1;
      end
      DEB1: if (pulse_cnt == PULSE_LAST) state_nxt = PLAY;
      DEB2: if (v8_fall && fall_seen) state_nxt = PLAY;
      PLAY: if (GAME_OVER) state_nxt = OVER;
      OVER: if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      pulse_cnt     <= '0;
      hold_cnt      <= '0;
      fall_seen     <= 1'b0;
      v8_d          <= 1'b0;
      _1_CR_START_N <= 1'b1;
      _2_CR_START   <= 1'b0;
      ATTRACT       <= 1'b1;
      ATTRACT_N     <= 1'b0;
      PLAYING       <= 1'b0;
      PLAYERS2      <= 1'b0;
    end else begin
      state         <= state_nxt;
      v8_d          <= _8V;
      pulse_cnt     <= (state == DEB1) ? pulse_cnt + 1'b1 : '0;
      hold_cnt      <= (state == OVER) ? hold_cnt + 1'b1 : '0;
      fall_seen     <= (state == DEB2) && (fall_seen || v8_fall);
      _1_CR_START_N <= (state_nxt != DEB1);
      _2_CR_START   <= (state_nxt == DEB2);
      ATTRACT       <= (state_nxt == IDLE) || (state_nxt == OVER);
      ATTRACT_N     <= !((state_nxt == IDLE) || (state_nxt == OVER));
      PLAYING       <= (state_nxt == PLAY);
      if (state == IDLE && state_nxt == DEB2)
        PLAYERS2 <= 1'b1;
      else if (state == IDLE && state_nxt == DEB1)
        PLAYERS2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_start_ctrl.sv
// tb/tb_start_ctrl.sv - scoreboard bench for start_ctrl
module tb_start_ctrl;
  localparam int DEB = 4;
  localparam int PW  = 4;
  localparam int OH  = 8;
  // {_1_CR_START_N, _2_CR_START, ATTRACT, ATTRACT_N, PLAYING, PLAYERS2}
  localparam logic [5:0] IDLE0 = 6'b101000;
  localparam logic [5:0] IDLE1 = 6'b101001;
  localparam logic [5:0] D1    = 6'b000100;
  localparam logic [5:0] D2    = 6'b110101;
  localparam logic [5:0] PL0   = 6'b100110;
  localparam logic [5:0] PL1   = 6'b100111;

  typedef struct {
    int         cyc;
    logic [5:0] val;
    string      name;
  } exp_t;

  exp_t chg_q[$];
  exp_t snap_q[$];

  logic clk = 0, rst_n = 0, start1 = 0, start2 = 0, cr1 = 0, cr2 = 0, v8 = 0, game_over = 0;
  logic n1, c2, att, att_n, play, p2;
  logic [5:0] outs;
  int cyc = 0, checks = 0, failures = 0;
  bit mon_en = 0;
  int k, m;

  start_ctrl #(.DEBOUNCE(DEB), .PULSE_W(PW), .OVER_HOLD(OH)) dut (
    .CLK_DRV(clk), .RESET_N(rst_n), .START1(start1), .START2(start2),
    ._1_OR_2_CREDIT(cr1), ._2_CREDIT(cr2), ._8V(v8), .GAME_OVER(game_over),
    ._1_CR_START_N(n1), ._2_CR_START(c2), .ATTRACT(att), .ATTRACT_N(att_n),
    .PLAYING(play), .PLAYERS2(p2)
  );

  assign outs = {n1, c2, att, att_n, play, p2};

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // _8V as seen at edge e equals bit 3 of e: falls land on multiples of 16
  initial begin
    int t;
    forever begin
      @(negedge clk);
      t  = cyc + 1;
      v8 = t[3];
    end
  end

  initial begin
    logic [5:0] prev;
    bit first;
    exp_t e;
    first = 1;
    prev  = '0;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (mon_en) begin
        if (first) begin
          prev  = outs;
          first = 0;
        end
        if (outs !== prev) begin
          checks++;
          if (chg_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change cyc=%0d got=%b was=%b", cyc, outs, prev);
          end else begin
            e = chg_q.pop_front();
            if (e.val !== outs || e.cyc != cyc) begin
              failures++;
              $display("FAIL %s got=%b at cyc %0d required=%b at cyc %0d", e.name, outs, cyc, e.val, e.cyc);
            end
          end
          prev = outs;
        end
        if (snap_q.size() != 0 && snap_q[0].cyc == cyc) begin
          e = snap_q.pop_front();
          checks++;
          if (e.val !== outs) begin
            failures++;
            $display("FAIL %s got=%b required=%b cyc=%0d", e.name, outs, e.val, cyc);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic go_phase(input int p);
    while (cyc % 16 != p) @(negedge clk);
  endtask

  task automatic exp_chg(input int c, input logic [5:0] v, input string n);
    exp_t e;
    e.cyc = c; e.val = v; e.name = n;
    chg_q.push_back(e);
  endtask

  task automatic exp_snap(input int c, input logic [5:0] v, input string n);
    exp_t e;
    e.cyc = c; e.val = v; e.name = n;
    snap_q.push_back(e);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((chg_q.size() != 0 || snap_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (chg_q.size() != 0 || snap_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", chg_q.size() + snap_q.size());
      chg_q.delete();
      snap_q.delete();
    end
  endtask

  task automatic press_1p(input string n);
    int kk;
    kk = cyc;
    start1 = 1;
    exp_chg(kk + 7,  D1,  {n, "_debit"});
    exp_chg(kk + 11, PL0, {n, "_play"});
    drain(40);
    start1 = 0;
    step(10);
  endtask

  task automatic end_game(input logic [5:0] idle_val);
    int mm;
    mm = cyc;
    game_over = 1;
    exp_chg(mm + 1, idle_val, "game_over_attract");
    step(1);
    game_over = 0;
    step(OH + 4);
  endtask

  initial begin
    step(3);
    exp_snap(cyc, IDLE0, "reset_state");
    mon_en = 1;
    step(1);
    rst_n = 1;
    step(2);
    cr1 = 1;

    press_1p("p1_start");

    // press landing while still in OVER is dropped
    m = cyc;
    game_over = 1;
    exp_chg(m + 1, IDLE0, "over_attract");
    step(1);
    game_over = 0;
    go_to(m + 2);
    start1 = 1;
    step(20);
    exp_snap(cyc, IDLE0, "over_press_dropped");
    step(1);
    start1 = 0;
    step(10);
    press_1p("idle_press");

    // first event cycle that falls in IDLE is accepted
    m = cyc;
    game_over = 1;
    exp_chg(m + 1, IDLE0, "over_attract2");
    step(1);
    game_over = 0;
    go_to(m + 3);
    start1 = 1;
    exp_chg(m + 10, D1,  "hold_boundary_debit");
    exp_chg(m + 14, PL0, "hold_boundary_play");
    drain(40);
    start1 = 0;
    step(10);
    end_game(IDLE0);

    // reset during the second cycle of the debit pulse, switch held throughout
    k = cyc;
    start1 = 1;
    exp_chg(k + 7, D1, "rst_debit");
    go_to(k + 8);
    #2;
    exp_chg(k + 8, IDLE0, "async_reset");
    rst_n = 0;
    go_to(k + 10);
    rst_n = 1;
    exp_chg(k + 17, D1,  "held_retrigger_debit");
    exp_chg(k + 21, PL0, "held_retrigger_play");
    drain(40);
    step(20);
    start1 = 0;
    step(10);
    end_game(IDLE0);

    // no credit: events discarded, later credit does not revive them
    cr1 = 0;
    start1 = 1;
    start2 = 1;
    step(20);
    cr1 = 1;
    cr2 = 1;
    step(10);
    exp_snap(cyc, IDLE0, "no_credit_idle");
    step(1);
    start1 = 0;
    start2 = 0;
    cr2 = 0;
    step(10);

    // bounce shorter than DEBOUNCE
    for (int i = 0; i < 16; i++) begin
      start1 = ~start1;
      step(2);
    end
    step(12);
    exp_snap(cyc, IDLE0, "bounce_idle");
    step(1);

    // 2P start entering DEB2 while _8V is high
    cr2 = 1;
    go_phase(5);
    k = cyc;
    start2 = 1;
    exp_chg(k + 7,  D2,  "p2_window");
    exp_chg(k + 27, PL1, "p2_play");
    drain(60);
    start2 = 0;
    step(10);
    end_game(IDLE1);

    // simultaneous press, entry while _8V is low
    go_phase(13);
    k = cyc;
    start1 = 1;
    start2 = 1;
    exp_chg(k + 7,  D2,  "prio_window");
    exp_chg(k + 35, PL1, "prio_play");
    drain(60);
    start1 = 0;
    start2 = 0;
    step(10);
    end_game(IDLE1);

    cr2 = 0;
    press_1p("p1_after_p2");
    step(5);

    checks++;
    if (chg_q.size() + snap_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations pending=%0d required=0", chg_q.size() + snap_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
